imem_program_loader: RTL and testbench
======================================

// Module: imem_program_loader
// PURPOSE
//   Writer side of the instruction-memory interface: the pipeline only reads imem. This block fills imem at run time.
//   It accepts a byte stream over a valid/ready handshake and packs each 4 bytes big-endian into one 32-bit instruction.
//   It writes each word to consecutive word-aligned imem addresses.
//   It holds the pipeline in reset (cpu_hold) until the program is fully written.
// PARAMETERS
//   ADDR_WIDTH  9   imem byte-address width; depth = 2**(ADDR_WIDTH-2) words
//   BASE_ADDR   0   byte address of first word written; must be a multiple of 4
// PORTS
//   clk         in   1             system clock, all state changes on posedge
//   reset       in   1             asynchronous, active-high; clears all state
//   start       in   1             1-cycle pulse; begins a load, sampled only in IDLE/DONE
//   word_count  in   ADDR_WIDTH-1  number of 32-bit words to load, sampled with start
//   byte_in     in   8             stream data byte
//   byte_valid  in   1             byte_in valid
//   byte_ready  out  1             loader accepts byte this cycle (transfer = valid & ready)
//   mem_we      out  1             imem word write strobe, 1 cycle per word
//   mem_addr    out  ADDR_WIDTH    imem byte address of write, word-aligned
//   mem_wdata   out  32            instruction word to write
//   cpu_hold    out  1             1 = pipeline held in reset
//   busy        out  1             load in progress (RECV or WRITE)
//   done        out  1             last load completed successfully
//   error       out  1             last start rejected: word_count > depth
//   checksum    out  32            mod-2^32 sum of all words written in current load
// BEHAVIOUR
//   Reset values: state=IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
//     cpu_hold=1, busy=0, done=0, error=0, checksum=0, byte counter=0, words_left=0.
//   FSM states: IDLE, RECV, WRITE, DONE.
//   IDLE/DONE + start:
//     word_count > 2**(ADDR_WIDTH-2): error=1, done=0, go to/stay in IDLE, cpu_hold=1.
//     word_count == 0: done=1, error=0, go to DONE, nothing written.
//     otherwise: error=0, done=0, checksum=0, mem_addr=BASE_ADDR, words_left=word_count.
//       cpu_hold=1; go to RECV.
//   RECV: byte_ready=1. Each transfer shifts the byte into the assembly register, first byte to [31:24].
//     The 4th transfer loads mem_wdata and goes to WRITE.
//     byte_valid low stalls indefinitely with no timeout; bytes are never dropped.
//   WRITE (exactly 1 cycle): mem_we=1, byte_ready=0, checksum += mem_wdata, words_left--.
//     If words_left was 1: go to DONE. Otherwise mem_addr += 4 on exit and go to RECV.
//   DONE: cpu_hold=0, done=1; byte_ready=0. Stray bytes are not accepted.
//   Latency: mem_we asserts the cycle after the 4th byte transfer.
//     cpu_hold falls the cycle after the last WRITE.
//   start while busy: ignored. word_count changes outside start: ignored.
//   mem_addr wraps modulo 2**ADDR_WIDTH. Overflow cannot happen at BASE_ADDR=0 because of the depth check.
//   busy = (state==RECV || state==WRITE). byte_ready is a registered/state decode, never combinational on byte_valid.
//   Reset mid-load: immediate return to reset values. Partial word discarded, cpu_hold=1.
//     imem contents already written are left as-is.
// TESTING
//   1. start, word_count=2; bytes 20,01,00,05,AC,22,00,08 with valid always high.
//      -> we at 0x000 data 0x20010005, we at 0x004 data 0xAC220008.
//      -> checksum 0xCC23000D, done=1, cpu_hold falls 1 cycle after 2nd we.
//   2. Same stream with byte_valid toggled 1/0 every cycle
//      -> identical writes and checksum; byte_ready stays 1 throughout RECV.
//   3. start with word_count=129 (ADDR_WIDTH=9) -> error=1, no mem_we, cpu_hold=1.
//      Then start with word_count=1 -> error clears and the load completes.
//   4. start, word_count=0 -> done=1 and cpu_hold=0 next cycle, no byte_ready, no mem_we.
//   5. reset asserted after 2 bytes of word 1 -> all outputs at reset values asynchronously.
//      Then a fresh load of 1 word writes at 0x000 with correct data.
//   6. start pulsed in RECV with word_count=5 -> ignored, original count completes.
//      Then start again in DONE reloads: cpu_hold=1, done=0, checksum cleared.

Source files
------------

// File: rtl/imem_program_loader.sv
// Run-time instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them to consecutive imem addresses and holds the CPU in reset until the load completes.
module imem_program_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH    = {2'b01, {(ADDR_WIDTH-2){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] STEP     = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [ADDR_WIDTH-2:0] ONE_WORD = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-2:0] NO_WORDS = {(ADDR_WIDTH-1){1'b0}};

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [23:0]             asm_q, asm_d;
    logic [ADDR_WIDTH-2:0]   left_q, left_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             sum_q, sum_d;
    logic                    error_q, error_d;
    logic                    ready_q, ready_d;
    logic                    we_q, we_d;
    logic                    hold_q, hold_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        left_d  = left_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sum_d   = sum_q;
        error_d = error_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if ({1'b0, word_count} > DEPTH) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else if (word_count == NO_WORDS) begin
                        error_d = 1'b0;
                        sum_d   = 32'd0;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b0;
                        sum_d   = 32'd0;
                        addr_d  = BASE;
                        left_d  = word_count;
                        cnt_d   = 2'd0;
                        state_d = RECV;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RECV: begin
                if (byte_valid && ready_q) begin
                    if (cnt_q == 2'd3) begin
                        wdata_d = {asm_q, byte_in};
                        cnt_d   = 2'd0;
                        state_d = WRITE;
                    end else begin
                        asm_d = {asm_q[15:0], byte_in};
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            WRITE: begin
                sum_d  = sum_q + wdata_q;
                left_d = left_q - ONE_WORD;
                if (left_q == ONE_WORD) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + STEP;
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are flopped from the next state so they line up with state_q
        ready_d = (state_d == RECV);
        we_d    = (state_d == WRITE);
        busy_d  = (state_d == RECV) || (state_d == WRITE);
        done_d  = (state_d == DONE);
        hold_d  = (state_d != DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            asm_q   <= 24'd0;
            left_q  <= NO_WORDS;
            addr_q  <= BASE;
            wdata_q <= 32'd0;
            sum_q   <= 32'd0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            left_q  <= left_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sum_q   <= sum_d;
            error_q <= error_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign byte_ready = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign checksum   = sum_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: table of load vectors plus hand sequences,
// with a write scoreboard fed by the byte driver and drained by a mem_we monitor.
module tb_imem_program_loader;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-2:0] word_count = '0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready, mem_we, cpu_hold, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, checksum;

    imem_program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we must match the next scoreboard entry
    wr_t  mon_e;
    int   last_we_cyc = -1;
    int   hold_fall_cyc = -1;
    logic prev_hold = 1'b1;
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: got write addr %03h data %08h expected none", mem_addr, mem_wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("we_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("we_data", mem_wdata, mon_e.data);
                chk("we_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
            last_we_cyc = cyc;
        end
        if (prev_hold === 1'b1 && cpu_hold === 1'b0) hold_fall_cyc = cyc;
        prev_hold = cpu_hold;
    end

    task automatic do_start(input logic [AW-2:0] wc);
        start = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
        word_count = AW'($urandom_range(0, 255));
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input bit tog);
        wr_t e;
        int  n;
        for (int k = 0; k < 4; k++) begin
            if (tog) begin
                byte_valid = 1'b0;
                @(negedge clk);
                chk("ready_in_recv", 32'(byte_ready), 32'd1);
            end
            n = 0;
            while (byte_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("ready_timeout", 32'(byte_ready), 32'd1);
            byte_in = w[31-8*k -: 8];
            byte_valid = 1'b1;
            if (k == 3) begin
                e.addr = AW'(4 * idx);
                e.data = w;
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        byte_valid = 1'b0;
        while ((busy !== 1'b0 || mem_we !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        #1;
    endtask

    typedef struct {
        logic [AW-2:0] wc;
        bit            toggle;
        logic [31:0]   w0;
        logic [31:0]   w1;
        logic [31:0]   exp_sum;
        bit            use_sum;
        bit            exp_done;
        bit            exp_err;
    } vec_t;

    localparam int NV = 8;
    vec_t v[NV];

    function automatic logic [31:0] word_of(input vec_t t, input int i);
        if (i == 0) return t.w0;
        else if (i == 1) return t.w1;
        else return t.w1 + 32'(i) * 32'h9E3779B9;
    endfunction

    logic [31:0] acc, w, exp_cs;
    int          nw;

    initial begin
        v[0] = '{8'd2,   1'b0, 32'h20010005, 32'hAC220008, 32'hCC23000D, 1'b1, 1'b1, 1'b0};
        v[1] = '{8'd2,   1'b1, 32'h20010005, 32'hAC220008, 32'hCC23000D, 1'b1, 1'b1, 1'b0};
        v[2] = '{8'd129, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        v[3] = '{8'd1,   1'b0, 32'h12345678, 32'h0,        32'h12345678, 1'b1, 1'b1, 1'b0};
        v[4] = '{8'd0,   1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
        v[5] = '{8'd255, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        v[6] = '{8'd2,   1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b1, 1'b1, 1'b0};
        v[7] = '{8'd128, 1'b0, 32'hA5A5A5A5, 32'h00000004, 32'h0,        1'b0, 1'b1, 1'b0};

        #2 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            acc = 32'd0;
            do_start(v[i].wc);
            if (v[i].exp_err) begin
                chk("rej_error", 32'(error), 32'd1);
                chk("rej_done", 32'(done), 32'd0);
                chk("rej_hold", 32'(cpu_hold), 32'd1);
                chk("rej_busy", 32'(busy), 32'd0);
            end else if (v[i].wc == '0) begin
                chk("zero_done", 32'(done), 32'd1);
                chk("zero_hold", 32'(cpu_hold), 32'd0);
                chk("zero_ready", 32'(byte_ready), 32'd0);
                chk("zero_busy", 32'(busy), 32'd0);
            end else begin
                chk("go_busy", 32'(busy), 32'd1);
                chk("go_hold", 32'(cpu_hold), 32'd1);
                chk("go_done", 32'(done), 32'd0);
                chk("go_error", 32'(error), 32'd0);
                chk("go_checksum", checksum, 32'd0);
            end
            nw = v[i].exp_err ? 0 : int'(v[i].wc);
            for (int j = 0; j < nw; j++) begin
                w = word_of(v[i], j);
                acc = acc + w;
                send_word(w, j, v[i].toggle);
            end
            wait_idle();
            chk("end_done", 32'(done), 32'(v[i].exp_done));
            chk("end_error", 32'(error), 32'(v[i].exp_err));
            chk("end_hold", 32'(cpu_hold), 32'(!v[i].exp_done));
            if (nw > 0) begin
                exp_cs = v[i].use_sum ? v[i].exp_sum : acc;
                chk("end_checksum", checksum, exp_cs);
                chk("hold_fall_latency", 32'(hold_fall_cyc), 32'(last_we_cyc + 1));
            end
            chk("sb_drained", 32'(sb.size()), 32'd0);
        end

        // Reset in the middle of the second word of a two-word load
        do_start(8'd2);
        send_word(32'h01020304, 0, 1'b0);
        byte_valid = 1'b0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        @(negedge clk);
        byte_in = 8'hBB;
        @(negedge clk);
        byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_checksum", checksum, 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_start(8'd1);
        send_word(32'hDEADBEEF, 0, 1'b0);
        wait_idle();
        chk("post_rst_checksum", checksum, 32'hDEADBEEF);
        chk("post_rst_done", 32'(done), 32'd1);

        // start while receiving is ignored; start from DONE reloads
        do_start(8'd2);
        send_word(32'h11223344, 0, 1'b0);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("busy_in_recv", 32'(byte_ready), 32'd1);
        do_start(8'd5);
        chk("busy_start_ignored", 32'(busy), 32'd1);
        send_word(32'h55667788, 1, 1'b0);
        wait_idle();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_checksum", checksum, 32'h6688AACC);
        byte_valid = 1'b1;
        byte_in = 8'h5A;
        repeat (3) @(negedge clk);
        chk("done_no_ready", 32'(byte_ready), 32'd0);
        chk("done_still_done", 32'(done), 32'd1);
        byte_valid = 1'b0;
        do_start(8'd1);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_checksum", checksum, 32'd0);
        send_word(32'hCAFEF00D, 0, 1'b0);
        wait_idle();
        chk("reload_end_checksum", checksum, 32'hCAFEF00D);
        chk("reload_end_hold", 32'(cpu_hold), 32'd0);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
